// File: rtl/dff_pkg.sv
// Shared constants and types for the NAND-gate edge-triggered flip-flop.
// Gate delays are only applied when DFF_GATE_DELAY_EN is defined.
`timescale 1ns/10ps
package dff_pkg;

   localparam logic    Q_RST    = 1'b0;
   localparam realtime GATE_DLY = 0.1;

   typedef struct packed {
      logic q;
      logic q_bar;
   } logic_pair_t;

endpackage

// File: rtl/dff_nand_if.sv
// Data and output bundle of the flip-flop; CLK and CLR remain plain ports.
`timescale 1ns/10ps
interface dff_nand_if;

   logic D;
   logic Q;
   logic Q_BAR;

   modport master (output D, input Q, input Q_BAR);
   modport slave  (input D, output Q, output Q_BAR);

endinterface

// File: rtl/nand_sr_latch.sv
// Cross-coupled 3-input NAND pair. Each gate sees its set/reset input, a gating
// input (low forces that gate high) and the other gate's output.
`timescale 1ns/10ps
module nand_sr_latch
   import dff_pkg::*;
(
   input  logic        s_n_i,
   input  logic        r_n_i,
   input  logic        ovr_s_n_i,
   input  logic        ovr_r_n_i,
   output logic_pair_t out_o
);

   logic q;
   logic q_bar;

`ifdef DFF_GATE_DELAY_EN
   assign #(GATE_DLY) q     = ~(s_n_i & ovr_s_n_i & q_bar);
   assign #(GATE_DLY) q_bar = ~(r_n_i & ovr_r_n_i & q);
`else
   assign q     = ~(s_n_i & ovr_s_n_i & q_bar);
   assign q_bar = ~(r_n_i & ovr_r_n_i & q);
`endif

   assign out_o = '{q, q_bar};

endmodule

// File: rtl/dff_nand.sv
// Positive-edge D flip-flop with async active-high clear, built from three NAND
// SR latches. Define DFF_GATE_DELAY_EN to give every NAND a GATE_DLY delay.
`timescale 1ns/10ps
module dff_nand
   import dff_pkg::*;
(
   input  logic       CLK,
   input  logic       CLR,
   dff_nand_if.slave  bus
);

   logic        pre_n;
   logic        clr_n;
   logic_pair_t lat_a;
   logic_pair_t lat_b;
   logic_pair_t lat_c;

   // CLR lands on the preset or the clear side depending on the reset value of Q.
   assign pre_n = (Q_RST == 1'b1) ? ~CLR : 1'b1;
   assign clr_n = (Q_RST == 1'b0) ? ~CLR : 1'b1;

   nand_sr_latch u_lat_a (
      .s_n_i     (lat_b.q_bar),
      .r_n_i     (CLK),
      .ovr_s_n_i (pre_n),
      .ovr_r_n_i (clr_n),
      .out_o     (lat_a)
   );

   nand_sr_latch u_lat_b (
      .s_n_i     (lat_a.q_bar),
      .r_n_i     (bus.D),
      .ovr_s_n_i (CLK),
      .ovr_r_n_i (clr_n),
      .out_o     (lat_b)
   );

   nand_sr_latch u_lat_c (
      .s_n_i     (lat_a.q_bar),
      .r_n_i     (lat_b.q),
      .ovr_s_n_i (pre_n),
      .ovr_r_n_i (clr_n),
      .out_o     (lat_c)
   );

   assign bus.Q     = lat_c.q;
   assign bus.Q_BAR = lat_c.q_bar;

endmodule

// File: tb/tb_dff_nand.sv
// Bench for dff_nand: table-driven stimulus on half-unit slots, a reference
// flip-flop model feeding a scoreboard, and a monitor sampling mid-slot.
`timescale 1ns/10ps
module tb_dff_nand;
   import dff_pkg::*;

   localparam int N_SLOT = 42;
   localparam int N_EV   = 14;

   logic CLK;
   logic CLR;

   dff_nand_if bus ();

   dff_nand dut (
      .CLK (CLK),
      .CLR (CLR),
      .bus (bus)
   );

   int   n_total = 0;
   int   n_bad   = 0;
   logic sb_q [$];

   // Slot k is time k*0.5; rising CLK edges fall on slots that are multiples of 4.
   int   ev_slot [N_EV] = '{0, 4, 6, 9, 11, 14, 18, 21, 22, 26, 30, 31, 33, 37};
   logic ev_clr  [N_EV] = '{1, 0, 0, 0, 0,  0,  0,  1,  0,  0,  0,  1,  0,  0};
   logic ev_d    [N_EV] = '{0, 0, 1, 0, 1,  0,  1,  1,  1,  0,  1,  1,  1,  0};

   logic mdl_q;
   logic clr_prev;
   logic d_prev;
   logic mon_want;
   int   ei;

   task automatic chk(input string tag, input logic obs, input logic want);
      n_total++;
      if (obs !== want) begin
         n_bad++;
         $display("FAIL %s t=%0.2f got=%b want=%b", tag, $realtime, obs, want);
      end
   endtask

   initial begin
      CLK = 1'b1;
      forever #1 CLK = ~CLK;
   end

   initial begin
      CLR      = 1'b1;
      bus.D    = 1'b0;
      mdl_q    = Q_RST;
      clr_prev = 1'b1;
      d_prev   = 1'b0;
      ei       = 0;
      for (int k = 0; k < N_SLOT; k++) begin
         if (ei < N_EV && ev_slot[ei] == k) begin
            CLR   = ev_clr[ei];
            bus.D = ev_d[ei];
            ei++;
         end
         if (CLR)
            mdl_q = Q_RST;
         else if ((k % 4 == 0) && !clr_prev)
            mdl_q = d_prev;
         sb_q.push_back(mdl_q);
         clr_prev = CLR;
         d_prev   = bus.D;
         #0.5;
      end
   end

   initial begin
      #0.4;
      for (int k = 0; k < N_SLOT; k++) begin
         chk($sformatf("sb_level@%0d", k), logic'(sb_q.size() > 0), 1'b1);
         if (sb_q.size() > 0) begin
            mon_want = sb_q.pop_front();
            chk($sformatf("q@%0d", k), bus.Q, mon_want);
            chk($sformatf("q_bar@%0d", k), bus.Q_BAR, ~mon_want);
         end
         #0.5;
      end
      chk("sb_drain", logic'(sb_q.size() == 0), 1'b1);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
